// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants, types and write-port arbitration for reg_file_mp
//   pick_writer(en, wa, a, zero) -> {hit, idx}: highest-index enabled write port
//   whose address equals a; never hits address 0 when zero is set.
package reg_file_pkg;

    localparam int DEF_M  = 32;
    localparam int DEF_N  = 8;
    localparam int MAX_NW = 2;
    localparam int MAX_AW = 16;

    typedef logic [MAX_AW-1:0] addr_t;
    typedef logic [MAX_NW-1:0] wen_t;
    typedef addr_t [MAX_NW-1:0] waddr_t;

    typedef struct packed {
        logic hit;
        logic idx;
    } pick_t;

    // Later ports overwrite earlier matches, so the highest index wins.
    function automatic pick_t pick_writer(input wen_t en, input waddr_t wa, input addr_t a, input logic zero);
        pick_t p;
        p = '0;
        for (int i = 0; i < MAX_NW; i++)
            if (en[i] && wa[i] == a && !(zero && a == '0)) begin
                p.hit = 1'b1;
                p.idx = i[0];
            end
        return p;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits for hazard detection
//   clk, n_reset     : clock, asynchronous active-low reset
//   rsv_en, rsv_addr : mark rsv_addr busy at the next edge
//   clr              : one bit per register written this cycle; clears its busy bit
//   busy_vec         : registered busy state (bit 0 held low when ZERO_REG)
module reg_scoreboard #(
    parameter int M        = 32,
    parameter int ZERO_REG = 1,
    localparam int AddrSz  = $clog2(M)
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              rsv_en,
    input  logic [AddrSz-1:0] rsv_addr,
    input  logic [M-1:0]      clr,
    output logic [M-1:0]      busy_vec
);

    logic [M-1:0] set;

    always_comb begin
        set = '0;
        set[rsv_addr] = rsv_en;
        if (ZERO_REG != 0) set[0] = 1'b0;
    end

    // Set is applied after clear so a fresh reservation outlives a completing write.
    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) busy_vec <= '0;
        else busy_vec <= (busy_vec & ~clr) | set;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: NR-read / NW-write register file with bypass, zero register and busy scoreboard
//   clk, n_reset      : clock, asynchronous active-low reset (clears data and busy bits)
//   rd_addr/rd_data   : NR combinational read ports
//   rd_busy           : busy flag of each read address (combinational)
//   wr_en/addr/data   : NW write ports, highest index wins on address conflict
//   rsv_en/rsv_addr   : reserve a register (mark busy)
//   busy_vec          : registered scoreboard state
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int M        = DEF_M,
    parameter int N        = DEF_N,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AddrSz  = $clog2(M)
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic [NR-1:0][AddrSz-1:0]  rd_addr,
    output logic [NR-1:0][N-1:0]       rd_data,
    output logic [NR-1:0]              rd_busy,
    input  logic [NW-1:0]              wr_en,
    input  logic [NW-1:0][AddrSz-1:0]  wr_addr,
    input  logic [NW-1:0][N-1:0]       wr_data,
    input  logic                       rsv_en,
    input  logic [AddrSz-1:0]          rsv_addr,
    output logic [M-1:0]               busy_vec
);

    wen_t                    en_x;
    waddr_t                  wa_x;
    logic [MAX_NW-1:0][N-1:0] wd_x;
    logic [N-1:0]            mem [M];
    logic [M-1:0]            wr_hit;
    logic [M-1:0]            wr_idx;

    // Widen the write ports to the package's fixed shape so pick_writer can be shared.
    always_comb begin
        en_x = '0;
        wa_x = '0;
        wd_x = '0;
        for (int i = 0; i < NW; i++) begin
            en_x[i] = wr_en[i];
            wa_x[i] = addr_t'(wr_addr[i]);
            wd_x[i] = wr_data[i];
        end
    end

    always_comb begin
        pick_t p;
        wr_hit = '0;
        wr_idx = '0;
        for (int a = 0; a < M; a++) begin
            p = pick_writer(en_x, wa_x, addr_t'(a), ZERO_REG != 0);
            wr_hit[a] = p.hit;
            wr_idx[a] = p.idx;
        end
    end

    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            for (int a = 0; a < M; a++) mem[a] <= '0;
        end else begin
            for (int a = 0; a < M; a++) if (wr_hit[a]) mem[a] <= wd_x[wr_idx[a]];
        end

    // A forwarded write completes the result, so the read is no longer busy
    // unless the same register is being re-reserved this cycle.
    always_comb begin
        pick_t p;
        logic  fwd;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NR; k++) begin
            p = pick_writer(en_x, wa_x, addr_t'(rd_addr[k]), ZERO_REG != 0);
            fwd = (BYPASS != 0) && p.hit;
            rd_data[k] = fwd ? wd_x[p.idx] : mem[rd_addr[k]];
            rd_busy[k] = busy_vec[rd_addr[k]] && !(fwd && !(rsv_en && rsv_addr == rd_addr[k]));
        end
    end

    reg_scoreboard #(
        .M        (M),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .n_reset  (n_reset),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .clr      (wr_hit),
        .busy_vec (busy_vec)
    );

endmodule
